// File: rtl/tdm2_pkg.sv
// Shared definitions for the tdm2_demux receive path: state encoding, slot
// constants and default channel width.
package tdm2_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic SLOT_A = 1'b0;
  localparam logic SLOT_B = 1'b1;

  localparam int unsigned TDM2_WIDTH_DEF = 8;

endpackage

// File: rtl/tdm2_deser.sv
// Per-channel deserialiser: WIDTH-bit shift register with clear and shift
// enable; with TDM2_DEMUX_PARITY_EN it also keeps running parity of shifted bits.
module tdm2_deser
  import tdm2_pkg::*;
#(
  parameter int unsigned WIDTH     = TDM2_WIDTH_DEF,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
`ifdef TDM2_DEMUX_PARITY_EN
  output logic             o_par,
`endif
  output logic [WIDTH-1:0] o_word_nxt
);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_base;

  // Clear together with enable starts a fresh word holding just this bit.
  always_comb begin
    w_base     = i_clr ? '0 : r_shift;
    o_word_nxt = w_base;
    if (i_en) begin
      if (MSB_FIRST) o_word_nxt = {w_base[WIDTH-2:0], i_bit};
      else           o_word_nxt = {i_bit, w_base[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_shift <= '0;
    else        r_shift <= o_word_nxt;
  end

`ifdef TDM2_DEMUX_PARITY_EN
  logic r_par;
  logic w_par_nxt;

  always_comb begin
    w_par_nxt = (i_clr ? 1'b0 : r_par) ^ (i_en & i_bit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_par <= 1'b0;
    else        r_par <= w_par_nxt;
  end

  assign o_par = r_par;
`endif

endmodule

// File: rtl/tdm2_demux.sv
// 2:1 TDM bit-interleave receiver: frame lock on sync, A/B split, word output.
// Optional TDM2_DEMUX_PARITY_EN appends PA/PB even-parity slots to each frame.
module tdm2_demux
  import tdm2_pkg::*;
#(
  parameter int unsigned WIDTH     = TDM2_WIDTH_DEF,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_i,
  input  logic             din_vld_i,
  input  logic             sync_i,
  output logic             sel_o,
  output logic             locked_o,
  output logic [WIDTH-1:0] a_word_o,
  output logic [WIDTH-1:0] b_word_o,
  output logic             word_vld_o,
  output logic             sync_err_o
`ifdef TDM2_DEMUX_PARITY_EN
  ,
  output logic             a_perr_o,
  output logic             b_perr_o
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] IDX_PAR = CW'(WIDTH);
`ifdef TDM2_DEMUX_PARITY_EN
  localparam logic [CW-1:0] IDX_LAST = CW'(WIDTH);
`else
  localparam logic [CW-1:0] IDX_LAST = CW'(WIDTH - 1);
`endif

  state_e           r_state, w_state_nxt;
  logic             r_slot, w_slot_nxt;
  logic [CW-1:0]    r_idx, w_idx_nxt;
  logic             w_frame_start;
  logic             w_clr, w_a_en, w_b_en, w_done, w_err;
  logic [WIDTH-1:0] w_a_nxt, w_b_nxt;
  logic [WIDTH-1:0] r_a_word, r_b_word;
  logic             r_word_vld, r_sync_err;

  always_comb begin
    w_state_nxt   = r_state;
    w_slot_nxt    = r_slot;
    w_idx_nxt     = r_idx;
    w_clr         = 1'b0;
    w_a_en        = 1'b0;
    w_b_en        = 1'b0;
    w_done        = 1'b0;
    w_err         = 1'b0;
    w_frame_start = (r_slot == SLOT_A) && (r_idx == '0);
    if (din_vld_i) begin
      unique case (r_state)
        HUNT: begin
          if (sync_i) begin
            w_state_nxt = RUN;
            w_clr       = 1'b1;
            w_a_en      = 1'b1;
            w_slot_nxt  = SLOT_B;
            w_idx_nxt   = '0;
          end
        end
        RUN: begin
          if (sync_i && !w_frame_start) begin
            w_err      = 1'b1;
            w_clr      = 1'b1;
            w_a_en     = 1'b1;
            w_slot_nxt = SLOT_B;
            w_idx_nxt  = '0;
          end else begin
            // A0 restarts both channels; B already moved to the word outputs.
            w_clr      = w_frame_start;
            w_slot_nxt = ~r_slot;
            if (r_slot == SLOT_A) begin
              w_a_en = (r_idx != IDX_PAR);
            end else begin
              w_b_en = (r_idx != IDX_PAR);
              if (r_idx == IDX_LAST) begin
                w_done    = 1'b1;
                w_idx_nxt = '0;
              end else begin
                w_idx_nxt = r_idx + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TDM2_DEMUX_PARITY_EN
  logic w_a_par, w_b_par;
  logic r_pa, r_a_perr, r_b_perr;
`endif

  tdm2_deser #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_deser_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_en       (w_a_en),
    .i_bit      (din_i),
`ifdef TDM2_DEMUX_PARITY_EN
    .o_par      (w_a_par),
`endif
    .o_word_nxt (w_a_nxt)
  );

  tdm2_deser #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_deser_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_en       (w_b_en),
    .i_bit      (din_i),
`ifdef TDM2_DEMUX_PARITY_EN
    .o_par      (w_b_par),
`endif
    .o_word_nxt (w_b_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HUNT;
      r_slot     <= SLOT_A;
      r_idx      <= '0;
      r_a_word   <= '0;
      r_b_word   <= '0;
      r_word_vld <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot     <= w_slot_nxt;
      r_idx      <= w_idx_nxt;
      r_word_vld <= w_done;
      r_sync_err <= w_err;
      if (w_done) begin
        r_a_word <= w_a_nxt;
        r_b_word <= w_b_nxt;
      end
    end
  end

`ifdef TDM2_DEMUX_PARITY_EN
  // PB is the bit being accepted on completion, so it is compared directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pa     <= 1'b0;
      r_a_perr <= 1'b0;
      r_b_perr <= 1'b0;
    end else begin
      if (din_vld_i && (r_state == RUN) && (r_slot == SLOT_A) && (r_idx == IDX_PAR))
        r_pa <= din_i;
      if (w_done) begin
        r_a_perr <= r_pa ^ w_a_par;
        r_b_perr <= din_i ^ w_b_par;
      end
    end
  end

  assign a_perr_o = r_a_perr;
  assign b_perr_o = r_b_perr;
`endif

  assign sel_o      = r_slot;
  assign locked_o   = (r_state == RUN);
  assign a_word_o   = r_a_word;
  assign b_word_o   = r_b_word;
  assign word_vld_o = r_word_vld;
  assign sync_err_o = r_sync_err;

endmodule

// File: tb/tb_tdm2_demux.sv
// Scoreboard bench for tdm2_demux: MSB-first and LSB-first instances share
// one stream; a frame-level model predicts words, pulses and slot state.
module tb_tdm2_demux;

  localparam int unsigned W = 8;
`ifdef TDM2_DEMUX_PARITY_EN
  localparam int FRAME = 2 * W + 2;
`else
  localparam int FRAME = 2 * W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din_i = 1'b0;
  logic din_vld_i = 1'b0;
  logic sync_i = 1'b0;

  logic         sel_m, locked_m, vld_m, err_m;
  logic [W-1:0] a_m, b_m;
  logic         sel_l, locked_l, vld_l, err_l;
  logic [W-1:0] a_l, b_l;
`ifdef TDM2_DEMUX_PARITY_EN
  logic aperr_m, bperr_m, aperr_l, bperr_l;
`endif

  tdm2_demux #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .din_i(din_i), .din_vld_i(din_vld_i), .sync_i(sync_i),
    .sel_o(sel_m), .locked_o(locked_m), .a_word_o(a_m), .b_word_o(b_m),
    .word_vld_o(vld_m), .sync_err_o(err_m)
`ifdef TDM2_DEMUX_PARITY_EN
    , .a_perr_o(aperr_m), .b_perr_o(bperr_m)
`endif
  );

  tdm2_demux #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din_i(din_i), .din_vld_i(din_vld_i), .sync_i(sync_i),
    .sel_o(sel_l), .locked_o(locked_l), .a_word_o(a_l), .b_word_o(b_l),
    .word_vld_o(vld_l), .sync_err_o(err_l)
`ifdef TDM2_DEMUX_PARITY_EN
    , .a_perr_o(aperr_l), .b_perr_o(bperr_l)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;

  bit          fq[$];
  int unsigned vq[$];
  int unsigned eq[$];
  bit          m_locked = 1'b0;
  logic [W-1:0] m_a = '0, m_b = '0, m_a2 = '0, m_b2 = '0;
  bit          m_aperr = 1'b0, m_bperr = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endfunction

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) r[i] = x[int'(W) - 1 - i];
    return r;
  endfunction

  // Reference model: bits of the current frame kept in arrival order.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      fq.delete(); vq.delete(); eq.delete();
      m_locked = 1'b0;
      m_a = '0; m_b = '0; m_a2 = '0; m_b2 = '0;
      m_aperr = 1'b0; m_bperr = 1'b0;
    end else if (din_vld_i) begin
      if (sync_i) begin
        if (m_locked && fq.size() != 0) eq.push_back(cyc);
        fq.delete();
        fq.push_back(din_i);
        m_locked = 1'b1;
      end else if (m_locked) begin
        fq.push_back(din_i);
      end
      if (fq.size() == FRAME) begin
        for (int i = 0; i < int'(W); i++) begin
          m_a[int'(W) - 1 - i] = fq[2 * i];
          m_b[int'(W) - 1 - i] = fq[2 * i + 1];
          m_a2[i] = fq[2 * i];
          m_b2[i] = fq[2 * i + 1];
        end
`ifdef TDM2_DEMUX_PARITY_EN
        m_aperr = fq[2 * W] ^ (^m_a);
        m_bperr = fq[2 * W + 1] ^ (^m_b);
`endif
        vq.push_back(cyc);
        fq.delete();
      end
    end
  end

  // Monitor: compares both instances against the model on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      bit ev, ee;
      ev = (vq.size() > 0) && (vq[0] == cyc);
      ee = (eq.size() > 0) && (eq[0] == cyc);
      if (ev) void'(vq.pop_front());
      if (ee) void'(eq.pop_front());
      chk("word_vld",    32'(vld_m), 32'(ev));
      chk("word_vld_lsb", 32'(vld_l), 32'(ev));
      chk("sync_err",    32'(err_m), 32'(ee));
      chk("sync_err_lsb", 32'(err_l), 32'(ee));
      chk("locked",      32'(locked_m), 32'(m_locked));
      chk("locked_lsb",  32'(locked_l), 32'(m_locked));
      chk("sel",         32'(sel_m), m_locked ? 32'(fq.size() % 2) : 32'd0);
      chk("sel_lsb",     32'(sel_l), m_locked ? 32'(fq.size() % 2) : 32'd0);
      chk("a_word",      32'(a_m), 32'(m_a));
      chk("b_word",      32'(b_m), 32'(m_b));
      chk("a_word_lsb",  32'(a_l), 32'(m_a2));
      chk("b_word_lsb",  32'(b_l), 32'(m_b2));
`ifdef TDM2_DEMUX_PARITY_EN
      if (ev) begin
        chk("a_perr",     32'(aperr_m), 32'(m_aperr));
        chk("b_perr",     32'(bperr_m), 32'(m_bperr));
        chk("a_perr_lsb", 32'(aperr_l), 32'(m_aperr));
        chk("b_perr_lsb", 32'(bperr_l), 32'(m_bperr));
      end
`endif
    end
  end

  task automatic drive(input bit v, input bit s, input bit d);
    @(posedge clk);
    #1;
    din_vld_i = v;
    sync_i    = s;
    din_i     = d;
  endtask

  // Idle cycles carry random sync/data to show they are ignored without valid.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic send_bits(input logic [W-1:0] a, input logic [W-1:0] b, input int nbits,
                           input bit sync_first, input int gap, input bit paf, input bit pbf);
    bit bits[$];
    int c;
    for (int i = 0; i < int'(W); i++) begin
      bits.push_back(a[int'(W) - 1 - i]);
      bits.push_back(b[int'(W) - 1 - i]);
    end
    bits.push_back((^a) ^ paf);
    bits.push_back((^b) ^ pbf);
    c = 0;
    for (int j = 0; j < nbits; j++) begin
      if (gap != 0 && (c % gap) == gap - 1) begin
        idle(1);
        c++;
      end
      drive(1'b1, sync_first && j == 0, bits[j]);
      c++;
    end
  endtask

  task automatic frame(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input int gap);
    send_bits(a, b, FRAME, s, gap, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked_m), 32'd0);
    chk("rst_sel",    32'(sel_m), 32'd0);
    chk("rst_a",      32'(a_m), 32'd0);
    chk("rst_b",      32'(b_m), 32'd0);
    chk("rst_vld",    32'(vld_m), 32'd0);
    chk("rst_err",    32'(err_m), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Unsynchronised bits are dropped, then lock on sync.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'($urandom));
    frame(8'hA5, 8'h3C, 1'b1, 0);
    idle(3);
    frame(8'hA5, 8'h3C, 1'b1, 3);
    idle(2);
    frame(8'h01, 8'hFF, 1'b1, 0);
    frame(8'h80, 8'h00, 1'b0, 0);

    // Sync arriving at bit 7 breaks the frame and restarts it.
    send_bits(8'h55, 8'h66, 7, 1'b1, 0, 1'b0, 1'b0);
    frame(8'h12, 8'h34, 1'b1, 0);
    idle(2);

    // Asynchronous reset after bit 9 of a frame.
    send_bits(8'hC3, 8'h5A, 9, 1'b1, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    din_vld_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_locked", 32'(locked_m), 32'd0);
    chk("arst_sel",    32'(sel_m), 32'd0);
    chk("arst_a",      32'(a_m), 32'd0);
    chk("arst_b",      32'(b_m), 32'd0);
    chk("arst_a_lsb",  32'(a_l), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // LSB-first instance receives 8'hA5 when it is sent bit 0 first.
    frame(rev(8'hA5), 8'h0F, 1'b1, 0);
    idle(1);
    send_bits(8'h96, 8'h69, FRAME, 1'b1, 0, 1'b1, 1'b0);
    idle(2);

    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 6)); j++)
          drive(1'($urandom), $urandom_range(0, 7) == 0, 1'($urandom));
      end else if (kind == 1) begin
        send_bits(W'($urandom), W'($urandom), int'($urandom_range(1, FRAME - 1)),
                  1'($urandom), 0, 1'b0, 1'b0);
      end else begin
        send_bits(W'($urandom), W'($urandom), FRAME, 1'($urandom),
                  int'($urandom_range(0, 4)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0);
      end
    end
    idle(4);
    chk("pending_vld", 32'(vq.size()), 32'd0);
    chk("pending_err", 32'(eq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
